// File: rtl/mux6_rr_sched_pkg.sv
// mux6_rr_sched_pkg: shared FSM states and sizing for the round-robin mux scheduler
package mux6_rr_sched_pkg;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
  localparam int N_SRC = 6;
  localparam int SEL_W = 3;
endpackage

// File: rtl/mux6_rr_sched_sel_mux6.sv
// sel_mux6: 6:1 single-bit mux, zero for out-of-range selects
module sel_mux6
  import mux6_rr_sched_pkg::*;
(
  input  logic [N_SRC-1:0] d,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);
  logic [7:0] dx;
  assign dx = {2'b00, d};
  assign y = dx[sel];
endmodule

// File: rtl/mux6_rr_sched.sv
// mux6_rr_sched: round-robin arbiter over six sources driving a registered mux select
module mux6_rr_sched
  import mux6_rr_sched_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] D,
  input  logic             out_ready,
  output logic [SEL_W-1:0] s,
  output logic [N_SRC-1:0] gnt,
  output logic             out_valid,
  output logic             out_data,
  output logic [CNT_W-1:0] xfer_cnt
);
  state_t state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, s_n;
  logic [N_SRC-1:0] gnt_n;
  logic ov_n;
  logic [CNT_W-1:0] cnt_n;
  logic [SEL_W:0] pick;
  // returns {found, index}; scanned backwards so the lowest offset from p wins
  function automatic logic [SEL_W:0] rr_pick(input logic [N_SRC-1:0] r, input logic [SEL_W-1:0] p);
    int k;
    rr_pick = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      k = int'(p) + i;
      k = (k >= N_SRC) ? k - N_SRC : k;
      if (r[k]) rr_pick = {1'b1, 3'(k)};
    end
  endfunction
  assign pick = rr_pick(req, ptr);
  always_comb begin
    state_n = state;
    s_n = s;
    gnt_n = gnt;
    ov_n = out_valid;
    ptr_n = ptr;
    cnt_n = xfer_cnt;
    if (state == IDLE && pick[SEL_W]) begin
      state_n = HOLD;
      s_n = pick[SEL_W-1:0];
      gnt_n = 6'b000001 << pick[SEL_W-1:0];
      ov_n = 1'b1;
    end else if (state == HOLD && out_ready) begin
      state_n = IDLE;
      gnt_n = '0;
      ov_n = 1'b0;
      ptr_n = (s == 3'd5) ? 3'd0 : s + 3'd1;
      cnt_n = xfer_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s <= '0;
      gnt <= '0;
      out_valid <= 1'b0;
      ptr <= '0;
      xfer_cnt <= '0;
    end else begin
      state <= state_n;
      s <= s_n;
      gnt <= gnt_n;
      out_valid <= ov_n;
      ptr <= ptr_n;
      xfer_cnt <= cnt_n;
    end
  end
  sel_mux6 u_mux (
    .d  (D),
    .sel(s),
    .y  (out_data)
  );
endmodule

// File: tb/tb_mux6_rr_sched.sv
// tb_mux6_rr_sched: directed stimulus checked against a cycle model of the arbiter
module tb_mux6_rr_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] req = '0;
  logic [5:0] d = '0;
  logic out_ready = 1'b0;
  logic [2:0] s, s2;
  logic [5:0] gnt, gnt2;
  logic out_valid, ov2, out_data, od2;
  logic [7:0] xfer_cnt;
  logic [1:0] cnt2;
  int checks = 0;
  int errors = 0;
  int m_ptr = 0, m_s = 0, m_cnt = 0;
  bit m_valid = 1'b0;
  mux6_rr_sched u_dut (
    .clk(clk), .rst(rst), .req(req), .D(d), .out_ready(out_ready),
    .s(s), .gnt(gnt), .out_valid(out_valid), .out_data(out_data), .xfer_cnt(xfer_cnt)
  );
  mux6_rr_sched #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req), .D(d), .out_ready(out_ready),
    .s(s2), .gnt(gnt2), .out_valid(ov2), .out_data(od2), .xfer_cnt(cnt2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // model: idle slot grants first requester from ptr onward; a held grant ends only on ready
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; m_s = 0; m_cnt = 0; m_valid = 1'b0;
    end else if (!m_valid) begin
      for (int k = 5; k >= 0; k--)
        if (req[(m_ptr + k) % 6]) begin
          m_s = (m_ptr + k) % 6;
          m_valid = 1'b1;
        end
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_ptr = (m_s + 1) % 6;
      m_cnt = m_cnt + 1;
    end
  end
  always @(negedge clk) begin
    chk("m_s", s, m_s);
    chk("m_gnt", gnt, m_valid ? (1 << m_s) : 0);
    chk("m_valid", out_valid, m_valid);
    chk("m_data", out_data, d[m_s]);
    chk("m_cnt", xfer_cnt, m_cnt % 256);
    chk("m_cnt2", cnt2, m_cnt % 4);
  end
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1; req = '0; out_ready = 1'b0; d = '0;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask
  int exp_s[7] = '{0, 1, 2, 3, 4, 5, 0};
  int exp_d[7] = '{0, 1, 0, 1, 1, 1, 0};
  int exp_c[5] = '{1, 2, 3, 0, 1};
  initial begin
    int n, guard;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_ov", out_valid, 0);
      chk("idle_gnt", gnt, 0);
      chk("idle_s", s, 0);
      chk("idle_cnt", xfer_cnt, 0);
    end
    do_reset();
    req = 6'h3f; out_ready = 1'b1; d = 6'b111010;
    n = 0; guard = 0;
    while (n < 7 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (out_valid) begin
        chk("rr_s", s, exp_s[n]);
        chk("rr_data", out_data, exp_d[n]);
        n++;
      end
    end
    chk("rr_grants", n, 7);
    #1 req = '0;
    @(negedge clk);
    chk("rr_cnt", xfer_cnt, 7);
    do_reset();
    req = 6'b100100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_s", s, 2);
      chk("hold_ov", out_valid, 1);
      if (i == 4) #1 out_ready = 1'b1;
    end
    @(negedge clk);
    chk("hold_done", out_valid, 0);
    @(negedge clk);
    chk("hold_next_s", s, 5);
    chk("hold_next_gnt", gnt, 6'b100000);
    do_reset();
    req = 6'b001000;
    @(negedge clk);
    chk("drop_gnt0", gnt, 6'b001000);
    chk("drop_d0", out_data, 0);
    #1 req = '0; d = 6'b001000;
    #1 chk("drop_follow", out_data, 1);
    repeat (2) begin
      @(negedge clk);
      chk("drop_gnt", gnt, 6'b001000);
      chk("drop_s", s, 3);
    end
    do_reset();
    req = 6'b000001; out_ready = 1'b1;
    @(negedge clk);
    chk("ar_s0", s, 0);
    #1 req = 6'b010000;
    @(negedge clk);
    chk("ar_cnt1", xfer_cnt, 1);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("ar_s4", s, 4);
    chk("ar_ov", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_rst_ov", out_valid, 0);
    chk("ar_rst_gnt", gnt, 0);
    chk("ar_rst_s", s, 0);
    chk("ar_rst_cnt", xfer_cnt, 0);
    @(negedge clk);
    #1 rst = 1'b0; req = 6'b010001;
    @(negedge clk);
    chk("ar_ptr_s", s, 0);
    #1 out_ready = 1'b1; req = 6'b010000;
    @(negedge clk);
    chk("ar_xfer", out_valid, 0);
    @(negedge clk);
    chk("ar_next_s", s, 4);
    do_reset();
    req = 6'b000001; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!out_valid && guard < 10);
      chk("wrap_wait", out_valid, 1);
      @(negedge clk);
      chk("wrap_cnt2", cnt2, exp_c[k]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux6_rr_sched.md
MUX6_RR_SCHED -- requirements
Module: mux6_rr_sched

Interface
REQ-001 Parameter CNT_W, default 8: width of the transfer counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  6  request per source; bit i = source i.
REQ-005 D  input  6  data bit per source; bit i = source i data.
REQ-006 out_ready  input  1  downstream accepts out_data this cycle.
REQ-007 s  output  3  registered mux select (0..5).
REQ-008 gnt  output  6  registered one-hot grant; gnt[i] set iff s==i and out_valid.
REQ-009 out_valid  output  1  registered; out_data is valid.
REQ-010 out_data  output  1  D[s], combinational through the sub-module mux.
REQ-011 xfer_cnt  output  CNT_W  registered count of completed transfers.

Function
REQ-012 FSM states SHALL be IDLE and HOLD only; encodings in the shared package.
REQ-013 Round-robin pointer ptr (3 bits, 0..5) SHALL give the highest-priority source: search order ptr, ptr+1, ..., wrapping 5->0.
REQ-014 IDLE, req==0: SHALL stay IDLE; s, gnt, out_valid unchanged from reset/last-clear values (out_valid=0, gnt=0).
REQ-015 IDLE, req!=0: SHALL register s = first set bit in search order, gnt = one-hot(s), out_valid=1, go to HOLD; latency req->out_valid = 1 cycle.
REQ-016 HOLD: s and gnt SHALL be stable until transfer (out_valid && out_ready on a rising edge).
REQ-017 HOLD: deassertion of req[s] SHALL NOT withdraw the grant; it holds until transfer.
REQ-018 Changes on D during HOLD SHALL propagate to out_data in the same cycle; no data capture.
REQ-019 On transfer: out_valid->0, gnt->0, ptr->(s==5 ? 0 : s+1), xfer_cnt->xfer_cnt+1 (wraps modulo 2^CNT_W), state->IDLE; s SHALL retain its value.
REQ-020 Throughput SHALL be one transfer per 2 cycles minimum (one IDLE bubble after every transfer).
REQ-021 out_ready while out_valid==0 SHALL have no effect.
REQ-022 s SHALL never take values 6 or 7.
REQ-023 Single requester asserting continuously SHALL be granted on every arbitration; all six asserting SHALL be served in order 0..5 repeating after reset.

Reset
REQ-024 rst high SHALL immediately set state=IDLE, s=0, gnt=0, out_valid=0, ptr=0, xfer_cnt=0, independent of clk.
REQ-025 rst asserted mid-HOLD SHALL abort the grant with no transfer counted.
REQ-026 First arbitration after reset release SHALL occur on the first rising edge with rst low and req!=0.

Structure
REQ-027 Shared package SHALL hold FSM state constants (IDLE, HOLD), source count (6), and select width (3).
REQ-028 One sub-module, sel_mux6 (6-bit data, 3-bit select, 1-bit output; output 0 for select 6/7), SHALL produce out_data.
REQ-029 Round-robin search SHALL be a combinational function inside mux6_rr_sched, not a separate module.

Verification
REQ-030 Reset then req=6'b000000 for 5 cycles -> out_valid=0, gnt=0, s=0, xfer_cnt=0 throughout.
REQ-031 req=6'b111111, out_ready=1, D=6'b111010 -> s sequence 0,1,2,3,4,5,0 on successive grants; out_data 0,1,0,1,1,1,0; xfer_cnt=7 after the 7th transfer.
REQ-032 req=6'b100100, ptr=0, out_ready=0 for 4 cycles then 1 -> s=2 held 5 cycles, then transfer; next grant s=5.
REQ-033 Grant s=3, drop req[3] and toggle D[3] 0->1 while out_ready=0 -> gnt=6'b001000 held, out_data follows D[3] to 1.
REQ-034 Assert rst during HOLD with s=4 -> out_valid, gnt, s, ptr, xfer_cnt all 0 before the next edge; next grant with req=6'b010000 gives s=4.
REQ-035 CNT_W=2, 5 transfers -> xfer_cnt sequence 1,2,3,0,1.
